// File: rtl/mem_access_stage.sv
// MEM stage: multi-cycle doubleword data memory, branch resolve, MEM/WB register and upstream stall.
// Define MEM_ACCESS_STATS_EN to add load/store/stall counter outputs.
module mem_access_stage #(
  parameter int DEPTH       = 256,
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_in,
  input  logic        zero_in,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] read_data2_in,
  input  logic [4:0]  write_reg_in,
  input  logic        branch_in,
  input  logic        memwrite_in,
  input  logic        memread_in,
  input  logic        memtoreg_in,
  input  logic        regwrite_in,
  output logic        pc_src_out,
  output logic [63:0] branch_target_out,
  output logic        stall_out,
  output logic [63:0] read_data_out,
  output logic [63:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        memtoreg_out,
  output logic        regwrite_out,
  output logic        misalign_out
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t r_state;
  state_t w_nextState;
  logic [3:0] r_count;
  logic [3:0] w_nextCount;
  logic [63:0] r_mem [DEPTH];

  logic w_memOp;
  logic w_isLoad;
  logic w_aligned;
  logic w_misalignedOp;
  logic w_stall;
  logic w_complete;
  logic [ADDR_BITS-1:0] w_index;
  logic w_unusedAddr;

  assign w_memOp        = memread_in | memwrite_in;
  assign w_isLoad       = memread_in & ~memwrite_in;
  assign w_aligned      = (alu_result_in[2:0] == 3'b000);
  assign w_misalignedOp = (r_state == IDLE) & w_memOp & ~w_aligned;
  assign w_index        = alu_result_in[ADDR_BITS+2:3];
  assign w_unusedAddr   = &{1'b0, alu_result_in[63:ADDR_BITS+3]};

  assign pc_src_out        = branch_in & zero_in;
  assign branch_target_out = pc_in;
  assign stall_out         = w_stall;

  // BUSY counts down the remaining stall cycles; the access retires when it reaches 0
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_stall     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memOp && w_aligned) begin
          if (MEM_LATENCY == 1) begin
            w_complete = 1'b1;
          end else begin
            w_stall     = 1'b1;
            w_nextState = BUSY;
            w_nextCount = 4'(MEM_LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (r_count != 4'd0) begin
          w_stall     = 1'b1;
          w_nextCount = r_count - 4'd1;
        end else begin
          w_complete  = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_complete && memwrite_in) begin
      r_mem[w_index] <= read_data2_in;
    end
  end

  // Stalled cycles push a bubble; misaligned ops retire with writeback suppressed
  always_ff @(posedge clk) begin
    if (rst || w_stall) begin
      read_data_out  <= '0;
      alu_result_out <= '0;
      write_reg_out  <= '0;
      memtoreg_out   <= 1'b0;
      regwrite_out   <= 1'b0;
      misalign_out   <= 1'b0;
    end else if (w_misalignedOp) begin
      read_data_out  <= '0;
      alu_result_out <= alu_result_in;
      write_reg_out  <= write_reg_in;
      memtoreg_out   <= memtoreg_in;
      regwrite_out   <= 1'b0;
      misalign_out   <= 1'b1;
    end else begin
      read_data_out  <= (w_complete && w_isLoad) ? r_mem[w_index] : '0;
      alu_result_out <= alu_result_in;
      write_reg_out  <= write_reg_in;
      memtoreg_out   <= memtoreg_in;
      regwrite_out   <= regwrite_in;
      misalign_out   <= 1'b0;
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      load_count  <= '0;
      store_count <= '0;
      stall_count <= '0;
    end else begin
      if (w_complete && w_isLoad) load_count <= load_count + 32'd1;
      if (w_complete && memwrite_in) store_count <= store_count + 32'd1;
      if (w_stall) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage at MEM_LATENCY 2, with latency-1 and latency-4 copies sharing the inputs.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pcIn;
  logic        zeroIn;
  logic [63:0] aluIn;
  logic [63:0] dataIn;
  logic [4:0]  wregIn;
  logic        branchIn, memwriteIn, memreadIn, memtoregIn, regwriteIn;

  logic        d2PcSrc, d1PcSrc, d4PcSrc;
  logic [63:0] d2Target, d1Target, d4Target;
  logic        d2Stall, d1Stall, d4Stall;
  logic [63:0] d2Rdata, d1Rdata, d4Rdata;
  logic [63:0] d2Alu, d1Alu, d4Alu;
  logic [4:0]  d2Wreg, d1Wreg, d4Wreg;
  logic        d2Mtr, d1Mtr, d4Mtr;
  logic        d2Rw, d1Rw, d4Rw;
  logic        d2Mis, d1Mis, d4Mis;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] d2Ld, d2St, d2Sc, d1Ld, d1St, d1Sc, d4Ld, d4St, d4Sc;
`endif

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DEPTH(256), .ADDR_BITS(8), .MEM_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .pc_in(pcIn), .zero_in(zeroIn), .alu_result_in(aluIn),
    .read_data2_in(dataIn), .write_reg_in(wregIn), .branch_in(branchIn),
    .memwrite_in(memwriteIn), .memread_in(memreadIn), .memtoreg_in(memtoregIn),
    .regwrite_in(regwriteIn), .pc_src_out(d2PcSrc), .branch_target_out(d2Target),
    .stall_out(d2Stall), .read_data_out(d2Rdata), .alu_result_out(d2Alu),
    .write_reg_out(d2Wreg), .memtoreg_out(d2Mtr), .regwrite_out(d2Rw),
    .misalign_out(d2Mis)
`ifdef MEM_ACCESS_STATS_EN
    , .load_count(d2Ld), .store_count(d2St), .stall_count(d2Sc)
`endif
  );

  mem_access_stage #(.DEPTH(256), .ADDR_BITS(8), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .pc_in(pcIn), .zero_in(zeroIn), .alu_result_in(aluIn),
    .read_data2_in(dataIn), .write_reg_in(wregIn), .branch_in(branchIn),
    .memwrite_in(memwriteIn), .memread_in(memreadIn), .memtoreg_in(memtoregIn),
    .regwrite_in(regwriteIn), .pc_src_out(d1PcSrc), .branch_target_out(d1Target),
    .stall_out(d1Stall), .read_data_out(d1Rdata), .alu_result_out(d1Alu),
    .write_reg_out(d1Wreg), .memtoreg_out(d1Mtr), .regwrite_out(d1Rw),
    .misalign_out(d1Mis)
`ifdef MEM_ACCESS_STATS_EN
    , .load_count(d1Ld), .store_count(d1St), .stall_count(d1Sc)
`endif
  );

  mem_access_stage #(.DEPTH(256), .ADDR_BITS(8), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .pc_in(pcIn), .zero_in(zeroIn), .alu_result_in(aluIn),
    .read_data2_in(dataIn), .write_reg_in(wregIn), .branch_in(branchIn),
    .memwrite_in(memwriteIn), .memread_in(memreadIn), .memtoreg_in(memtoregIn),
    .regwrite_in(regwriteIn), .pc_src_out(d4PcSrc), .branch_target_out(d4Target),
    .stall_out(d4Stall), .read_data_out(d4Rdata), .alu_result_out(d4Alu),
    .write_reg_out(d4Wreg), .memtoreg_out(d4Mtr), .regwrite_out(d4Rw),
    .misalign_out(d4Mis)
`ifdef MEM_ACCESS_STATS_EN
    , .load_count(d4Ld), .store_count(d4St), .stall_count(d4Sc)
`endif
  );

  // Sets the EX/MEM-side inputs for one op; branch inputs are driven separately
  task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] data,
                               input logic rd, input logic wr, input logic rw,
                               input logic mtr, input logic [4:0] wreg);
    aluIn      = addr;
    dataIn     = data;
    memreadIn  = rd;
    memwriteIn = wr;
    regwriteIn = rw;
    memtoregIn = mtr;
    wregIn     = wreg;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d1Stalls;
    int d4Stalls;
    int bubbles;

    rst = 1'b1;
    pcIn = '0;
    zeroIn = 1'b0;
    branchIn = 1'b0;
    applyStimulus(64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    checkOutput("reset rdata", d2Rdata, 64'h0);
    checkOutput("reset alu", d2Alu, 64'h0);
    checkOutput("reset regwrite", {63'h0, d2Rw}, 64'h0);
    checkOutput("reset misalign", {63'h0, d2Mis}, 64'h0);
    checkOutput("reset stall", {63'h0, d2Stall}, 64'h0);
    rst = 1'b0;

    $display("[TB] store then load at latency 2");
    applyStimulus(64'h40, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    checkOutput("store stall c0", {63'h0, d2Stall}, 64'h1);
    tick();
    checkOutput("store stall c1", {63'h0, d2Stall}, 64'h0);
    checkOutput("store bubble alu", d2Alu, 64'h0);
    tick();
    checkOutput("store retire alu", d2Alu, 64'h40);
    applyStimulus(64'h40, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    #1;
    checkOutput("load stall c0", {63'h0, d2Stall}, 64'h1);
    tick();
    checkOutput("load bubble regwrite", {63'h0, d2Rw}, 64'h0);
    checkOutput("load stall c1", {63'h0, d2Stall}, 64'h0);
    tick();
    checkOutput("load rdata", d2Rdata, 64'hDEADBEEF_CAFEF00D);
    checkOutput("load wreg", {59'h0, d2Wreg}, 64'h5);
    checkOutput("load regwrite", {63'h0, d2Rw}, 64'h1);
    checkOutput("load memtoreg", {63'h0, d2Mtr}, 64'h1);

    $display("[TB] misaligned store and pass-through");
    applyStimulus(64'h43, 64'h1111_2222_3333_4444, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3);
    #1;
    checkOutput("misalign stall", {63'h0, d2Stall}, 64'h0);
    tick();
    checkOutput("misalign flag", {63'h0, d2Mis}, 64'h1);
    checkOutput("misalign regwrite", {63'h0, d2Rw}, 64'h0);
    checkOutput("misalign rdata", d2Rdata, 64'h0);
    applyStimulus(64'h1234, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7);
    #1;
    checkOutput("alu op stall", {63'h0, d2Stall}, 64'h0);
    tick();
    checkOutput("alu op result", d2Alu, 64'h1234);
    checkOutput("alu op wreg", {59'h0, d2Wreg}, 64'h7);
    checkOutput("alu op misalign", {63'h0, d2Mis}, 64'h0);
    checkOutput("alu op regwrite", {63'h0, d2Rw}, 64'h1);
    applyStimulus(64'h40, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    tick();
    tick();
    checkOutput("load after misalign", d2Rdata, 64'hDEADBEEF_CAFEF00D);

    $display("[TB] address wrap");
    applyStimulus(64'h800, 64'h01234567_89ABCDEF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    applyStimulus(64'h0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
    tick();
    tick();
    checkOutput("wrap load", d2Rdata, 64'h01234567_89ABCDEF);

    $display("[TB] branch resolve");
    applyStimulus(64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    branchIn = 1'b1;
    zeroIn = 1'b1;
    pcIn = 64'h100;
    #1;
    checkOutput("branch taken", {63'h0, d2PcSrc}, 64'h1);
    checkOutput("branch target", d2Target, 64'h100);
    zeroIn = 1'b0;
    #1;
    checkOutput("branch not taken", {63'h0, d2PcSrc}, 64'h0);
    branchIn = 1'b0;
    tick();

    $display("[TB] reset during access");
    applyStimulus(64'h40, 64'h0000_0000_0000_0BAD, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2);
    tick();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("midreset rdata", d2Rdata, 64'h0);
    checkOutput("midreset alu", d2Alu, 64'h0);
    checkOutput("midreset regwrite", {63'h0, d2Rw}, 64'h0);
    checkOutput("midreset wreg", {59'h0, d2Wreg}, 64'h0);
    rst = 1'b0;
    applyStimulus(64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    checkOutput("midreset stall", {63'h0, d2Stall}, 64'h0);
    applyStimulus(64'h40, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    tick();
    tick();
    checkOutput("midreset no store", d2Rdata, 64'hDEADBEEF_CAFEF00D);

    $display("[TB] latency sweep");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(64'h80, 64'h55, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    d1Stalls = 0;
    d4Stalls = 0;
    bubbles = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      d1Stalls += int'(d1Stall);
      d4Stalls += int'(d4Stall);
      tick();
      if (i < 3 && d4Alu === 64'h0) bubbles++;
    end
    checkOutput("lat1 stall cycles", 64'(d1Stalls), 64'd0);
    checkOutput("lat4 stall cycles", 64'(d4Stalls), 64'd3);
    checkOutput("lat4 bubbles", 64'(bubbles), 64'd3);
    checkOutput("lat4 store retire", d4Alu, 64'h80);
    checkOutput("lat1 store retire", d1Alu, 64'h80);
    applyStimulus(64'h80, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
    #1;
    checkOutput("lat1 load stall", {63'h0, d1Stall}, 64'h0);
    tick();
    checkOutput("lat1 load rdata", d1Rdata, 64'h55);
    tick();
    tick();
    tick();
    checkOutput("lat4 load rdata", d4Rdata, 64'h55);
    checkOutput("lat4 load wreg", {59'h0, d4Wreg}, 64'h9);
    checkOutput("lat4 load regwrite", {63'h0, d4Rw}, 64'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage 64-bit RISC-V pipeline. Consumes EX/MEM register outputs: address (ALU result), store data, control.
- Performs doubleword loads/stores against an internal multi-cycle data memory.
- Resolves branch redirect from branch/zero.
- Drives the MEM/WB pipeline register. Freezes upstream via stall while a memory access is in flight.

Parameters:
- DEPTH, 256, number of 64-bit words in the data memory
- ADDR_BITS, 8, word-index width; must equal log2(DEPTH)
- MEM_LATENCY, 2, cycles per load/store, legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pc_in  in  64  branch target from EX/MEM
- zero_in  in  1  branch compare result
- alu_result_in  in  64  byte address, or ALU result for non-memory ops
- read_data2_in  in  64  store data
- write_reg_in  in  5  destination register
- branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in  in  1 each  control from EX/MEM
- pc_src_out  out  1  combinational: branch_in & zero_in
- branch_target_out  out  64  combinational: pc_in
- stall_out  out  1  combinational: hold PC, IF/ID, ID/EX, EX/MEM this cycle
- read_data_out  out  64  MEM/WB load data
- alu_result_out  out  64  MEM/WB ALU result
- write_reg_out  out  5  MEM/WB destination
- memtoreg_out, regwrite_out  out  1 each  MEM/WB control
- misalign_out  out  1  MEM/WB: the retired op was a misaligned memory access

Behaviour:
- Reset values:
  - All MEM/WB outputs and misalign_out are 0.
  - FSM is IDLE and the latency counter is 0.
  - Memory array is not reset.
- Memory op definition: mem_op = memread_in | memwrite_in. memread_in and memwrite_in both high: treat as store only.
- Addressing:
  - Word index = alu_result_in[ADDR_BITS+2:3]. Upper address bits are ignored (wraps modulo DEPTH*8 bytes).
  - Aligned means alu_result_in[2:0] == 0.
- FSM states are IDLE and BUSY; the counter is 4 bits.
  - IDLE, no mem_op: stall_out=0. MEM/WB captures inputs at the edge; read_data_out=0.
  - IDLE, misaligned mem_op: completes in 1 cycle with no stall. Store is suppressed. MEM/WB captures read_data_out=0, regwrite_out=0, misalign_out=1.
  - IDLE, aligned mem_op, MEM_LATENCY==1: completes at this edge with no stall.
  - IDLE, aligned mem_op, MEM_LATENCY>1: stall_out=1. Go to BUSY with counter=MEM_LATENCY-2. MEM/WB captures a bubble (regwrite_out=0, memtoreg_out=0, misalign_out=0, data 0).
  - BUSY, counter!=0: stall_out=1, counter decrements, MEM/WB captures a bubble.
  - BUSY, counter==0: stall_out=0, the access completes at this edge, return to IDLE.
- Completion edge:
  - Store writes read_data2_in to mem[index]. This is the only write for that op.
  - Load captures mem[index] (pre-edge contents) into read_data_out.
  - Control and alu_result forward to MEM/WB.
- Total: an aligned op presented in cycle T raises stall in cycles T..T+MEM_LATENCY-2 and retires at the end of cycle T+MEM_LATENCY-1.
- Inputs are held stable by upstream while stall_out=1; the stage samples address and data only at completion.
- Branch: pc_src_out/branch_target_out are purely combinational and independent of the FSM. Branches carry no mem_op.
- Reset mid-access (rst high in BUSY): next state is IDLE, no store is performed, MEM/WB clears. stall_out is 0 in the cycle after reset.
- Back-to-back aligned ops: each one pays the full MEM_LATENCY. There is no overlap.

Optional Feature:
- Macro: MEM_ACCESS_STATS_EN.
- Defined:
  - Adds outputs load_count, store_count and stall_count, each 32 bits, reset to 0, wrapping at 2^32.
  - load_count / store_count increment at the completion edge of each aligned load / store.
  - stall_count increments every cycle stall_out=1.
  - Misaligned ops are not counted.
- Undefined: the ports and the counter logic do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles mid-BUSY → all outputs 0, stall_out=0; a later load from that address shows no store occurred.
- Store then load, MEM_LATENCY=2: store 0xDEADBEEF_CAFEF00D to addr 0x40; stall_out=1 for exactly 1 cycle. Load addr 0x40 with write_reg_in=5, regwrite/memtoreg=1 → after 2 cycles read_data_out=0xDEADBEEF_CAFEF00D, write_reg_out=5, regwrite_out=1; bubble in between has regwrite_out=0.
- Latency sweep: MEM_LATENCY=1 → stall_out never asserts. MEM_LATENCY=4 → stall_out high exactly 3 cycles per op, 3 bubbles.
- Misaligned: store to addr 0x43 → no stall, misalign_out=1 for one MEM/WB cycle, regwrite_out=0; a subsequent load of 0x40 returns the prior value.
- Wrap and pass-through:
  - DEPTH=256: store to 0x800 (index 0), then load 0x0 → same data.
  - Non-memory op with alu_result_in=0x1234 → alu_result_out=0x1234 next cycle with no stall.
- Branch: branch_in=1, zero_in=1, pc_in=0x100 → pc_src_out=1, branch_target_out=0x100 same cycle. zero_in=0 → pc_src_out=0.
